// File: rtl/gf2_poly_divider_serial_if.sv
// gf2_poly_divider_serial_if: valid/ready request and result bundle for the serial GF(2) divider
interface gf2_poly_divider_serial_if #(parameter int DW = 16, parameter int VW = 8);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;
  modport master (output in_valid, dividend, divisor, out_ready,
                  input in_ready, out_valid, quotient, remainder, div_zero);
  modport slave (input in_valid, dividend, divisor, out_ready,
                 output in_ready, out_valid, quotient, remainder, div_zero);
endinterface

// File: rtl/gf2_poly_divider_serial.sv
// gf2_poly_divider_serial: bit-serial GF(2) polynomial long division, one dividend bit per cycle
module gf2_poly_divider_serial #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input logic clk,
  input logic rst,
  gf2_poly_divider_serial_if.slave bus
);
  localparam int DGW = VW > 1 ? $clog2(VW) : 1;
  localparam int CW = DW > 1 ? $clog2(DW) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] sh, q;
  logic [VW-1:0] v, r;
  logic [DGW-1:0] deg, deg_n;
  logic [CW-1:0] cnt;
  logic dz, accept;
  logic [VW:0] s, s_x;
  assign accept = bus.in_valid && state == IDLE;
  always_comb begin
    deg_n = '0;
    for (int i = 0; i < VW; i++) deg_n = bus.divisor[i] ? DGW'(i) : deg_n;
  end
  // partial remainder stays below deg, so s[deg] is the leading coefficient to cancel
  always_comb begin
    s = {r, sh[DW-1]};
    s_x = s[deg] ? s ^ {1'b0, v} : s;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (bus.divisor == '0 ? DONE : RUN) : IDLE;
      RUN: state_n = cnt == '0 ? DONE : RUN;
      DONE: state_n = bus.out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh <= '0;
      q <= '0;
      v <= '0;
      r <= '0;
      deg <= '0;
      cnt <= '0;
      dz <= 1'b0;
    end else if (accept) begin
      sh <= bus.dividend;
      q <= '0;
      v <= bus.divisor;
      r <= '0;
      deg <= deg_n;
      cnt <= CW'(DW - 1);
      dz <= bus.divisor == '0;
    end else if (state == RUN) begin
      sh <= sh << 1;
      q <= {q[DW-2:0], s[deg]};
      r <= s_x[VW-1:0];
      cnt <= cnt - 1'b1;
    end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.quotient = q;
  assign bus.remainder = r;
  assign bus.div_zero = dz;
endmodule

// File: tb/tb_gf2_poly_divider_serial.sv
// tb_gf2_poly_divider_serial: directed and round-trip checks of the serial GF(2) divider against a long-division model
module tb_gf2_poly_divider_serial;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_q;
  logic [7:0] exp_r;
  logic exp_dz;
  gf2_poly_divider_serial_if #(.DW(16), .VW(8)) bus ();
  gf2_poly_divider_serial #(.DW(16), .VW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [15:0] d, input logic [7:0] v,
                                output logic [15:0] q, output logic [7:0] r);
    logic [15:0] rem;
    int dv;
    rem = d;
    dv = -1;
    q = '0;
    r = '0;
    for (int i = 0; i < 8; i++) if (v[i]) dv = i;
    if (dv < 0) return;
    for (int i = 15; i >= dv; i--)
      if (rem[i]) begin
        rem ^= 16'(v) << (i - dv);
        q[i-dv] = 1'b1;
      end
    r = rem[7:0];
  endfunction

  function automatic logic [15:0] clmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    return p;
  endfunction

  always @(negedge clk)
    if (!rst && bus.out_valid) begin
      chk("cmp_quotient", 32'(bus.quotient), 32'(exp_q));
      chk("cmp_remainder", 32'(bus.remainder), 32'(exp_r));
      chk("cmp_div_zero", 32'(bus.div_zero), 32'(exp_dz));
      chk("cmp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end

  task automatic run_op(input logic [15:0] d, input logic [7:0] v, input int stall,
                        output logic [15:0] q, output logic [7:0] r, output int lat);
    @(negedge clk);
    model(d, v, exp_q, exp_r);
    exp_dz = v == 0;
    bus.in_valid = 1;
    bus.dividend = d;
    bus.divisor = v;
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.dividend = 16'($urandom);
    bus.divisor = 8'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      bus.in_valid = 1;
      bus.dividend = 16'($urandom);
      bus.divisor = 8'($urandom);
      @(posedge clk);
      #1;
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    end
    q = bus.quotient;
    r = bus.remainder;
    @(negedge clk);
    bus.in_valid = 0;
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    bus.out_ready = 0;
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] q, d;
    logic [7:0] r, a, b, rr;
    int lat, dv;
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.dividend = '0;
    bus.divisor = '0;
    exp_q = '0;
    exp_r = '0;
    exp_dz = 0;
    model(16'h0015, 8'h03, q, r);
    chk("model_pin_q", 32'(q), 32'h000C);
    chk("model_pin_r", 32'(r), 32'h01);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_quotient", 32'(bus.quotient), 32'd0);
    chk("reset_remainder", 32'(bus.remainder), 32'd0);
    chk("reset_div_zero", 32'(bus.div_zero), 32'd0);
    @(negedge clk);
    rst = 0;

    run_op(16'h0015, 8'h03, 0, q, r, lat);
    chk("t1_latency", 32'(lat), 32'd17);
    chk("t1_quotient", 32'(q), 32'h000C);
    chk("t1_remainder", 32'(r), 32'h01);
    run_op(16'hBEEF, 8'h01, 0, q, r, lat);
    chk("t2_quotient", 32'(q), 32'hBEEF);
    chk("t2_remainder", 32'(r), 32'h00);
    run_op(16'h0000, 8'h1B, 0, q, r, lat);
    chk("t2z_quotient", 32'(q), 32'h0000);
    chk("t2z_remainder", 32'(r), 32'h00);
    run_op(16'h1234, 8'h00, 0, q, r, lat);
    chk("t3_latency", 32'(lat), 32'd1);
    chk("t3_quotient", 32'(q), 32'h0000);
    chk("t3_remainder", 32'(r), 32'h00);
    run_op(16'hFFFF, 8'h80, 0, q, r, lat);
    chk("deg7_quotient", 32'(q), 32'h01FF);
    chk("deg7_remainder", 32'(r), 32'h7F);

    for (int k = 0; k < 1000; k++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      dv = 0;
      for (int i = 0; i < 8; i++) if (b[i]) dv = i;
      rr = 8'($urandom) & 8'((1 << dv) - 1);
      d = clmul(a, b) ^ 16'(rr);
      run_op(d, b, 0, q, r, lat);
      chk("rt_quotient", 32'(q), 32'(a));
      chk("rt_remainder", 32'(r), 32'(rr));
    end

    run_op(16'hA5C3, 8'h0B, 10, q, r, lat);
    chk("t5_latency", 32'(lat), 32'd17);

    @(negedge clk);
    model(16'h0015, 8'h03, exp_q, exp_r);
    exp_dz = 0;
    bus.in_valid = 1;
    bus.dividend = 16'h0015;
    bus.divisor = 8'h03;
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t6_rst_quotient", 32'(bus.quotient), 32'd0);
    @(negedge clk);
    rst = 0;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) lat++;
    end
    chk("t6_no_out_valid", 32'(lat), 32'd0);
    chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
    run_op(16'h0015, 8'h03, 0, q, r, lat);
    chk("t6_latency", 32'(lat), 32'd17);
    chk("t6_quotient", 32'(q), 32'h000C);
    chk("t6_remainder", 32'(r), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
